alu_operand_stage: RTL and testbench

- Operand-fetch/issue stage sitting directly upstream of the single-cycle ALU.
- Contains the 32-entry integer register file (x0 hardwired to zero), the register-vs-immediate mux for operand B, and a one-entry valid/ready output register.
- The output register drives the ALU's a, b and 3-bit opcode inputs.
- Write-back from later stages enters through a dedicated write port.

---
 rtl/alu_operand_stage.sv | 126 ++++++++++++
 tb/tb_alu_operand_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_operand_stage
//  Purpose  : Operand-fetch/issue stage in front of the single-cycle ALU.
//             Holds the 32-entry integer register file (x0 reads as zero),
//             selects register or immediate for operand B, and keeps one
//             valid/ready output entry that drives the ALU's a/b/opcode.
//  Options  : OPSTAGE_BYPASS_EN - when defined, a write-back in the accept
//             cycle that targets rs1/rs2 is forwarded into the captured
//             operand. When undefined, the pre-write value is captured.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [XLEN-1:0]   imm,
    input  logic              use_imm,
    input  logic [2:0]        op_in,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   a,
    output logic [XLEN-1:0]   b,
    output logic [2:0]        opcode,
    output logic              illegal_op
);

    localparam int c_NUM_REGS = 2 ** REG_AW;

    logic [XLEN-1:0] r_regs [c_NUM_REGS];

    logic            r_out_valid;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [2:0]      r_opcode;
    logic            r_illegal;

    logic            w_accept;
    logic            w_wb_active;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_b_sel;
    logic            w_illegal;

    // Write-back is dropped for x0 so that entry never leaves zero.
    assign w_wb_active = wb_we && (wb_addr != '0);

    // Register file write port; reset clears every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_active) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Combinational read ports, x0 forced to zero, optional same-cycle forwarding.
    always_comb begin
        w_rs1_val = (rs1 == '0) ? '0 : r_regs[rs1];
        w_rs2_val = (rs2 == '0) ? '0 : r_regs[rs2];
`ifdef OPSTAGE_BYPASS_EN
        if (w_wb_active && (wb_addr == rs1)) begin
            w_rs1_val = wb_data;
        end
        if (w_wb_active && (wb_addr == rs2)) begin
            w_rs2_val = wb_data;
        end
`endif
    end

    assign w_b_sel = use_imm ? imm : w_rs2_val;

    // Flag opcodes the ALU does not implement; the opcode itself passes through.
    always_comb begin
        w_illegal = 1'b1;
        case (op_in)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b101: w_illegal = 1'b0;
            default:                                w_illegal = 1'b1;
        endcase
    end

    // Ready does not look at flush so the issuer sees a stable handshake.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // One-entry output register; flush wins over a simultaneous accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_opcode    <= 3'b000;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_a         <= w_rs1_val;
            r_b         <= w_b_sel;
            r_opcode    <= op_in;
            r_illegal   <= w_illegal;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign a          = r_a;
    assign b          = r_b;
    assign opcode     = r_opcode;
    assign illegal_op = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_operand_stage
//  Purpose  : Scoreboard bench for alu_operand_stage. A reference model keeps
//             the register file as an array and the output buffer as a queue
//             of expected entries; a monitor compares the DUT against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [2:0]      op;
        logic            ill;
    } entry_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [REG_AW-1:0] rs1 = '0;
    logic [REG_AW-1:0] rs2 = '0;
    logic [XLEN-1:0]   imm = '0;
    logic              use_imm = 1'b0;
    logic [2:0]        op_in = 3'b000;
    logic              flush = 1'b0;
    logic              wb_we = 1'b0;
    logic [REG_AW-1:0] wb_addr = '0;
    logic [XLEN-1:0]   wb_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [2:0]        opcode;
    logic              illegal_op;

    int n_chk  = 0;
    int n_fail = 0;

    logic [XLEN-1:0] m_regs [32];
    entry_t          m_q[$];
    entry_t          m_last;

    alu_operand_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm        (imm),
        .use_imm    (use_imm),
        .op_in      (op_in),
        .flush      (flush),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .a          (a),
        .b          (b),
        .opcode     (opcode),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference read: x0 is zero; same-cycle write-back forwarded only with bypass.
    function automatic logic [XLEN-1:0] ref_read(input logic [REG_AW-1:0] r);
        if (r == 0) return '0;
`ifdef OPSTAGE_BYPASS_EN
        if (wb_we && wb_addr == r) return wb_data;
`endif
        return m_regs[r];
    endfunction

    // Reference model: one-deep buffer as a queue, updated on every clock edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_q.delete();
            m_last = '{a: '0, b: '0, op: 3'b000, ill: 1'b0};
        end else begin
            automatic bit     have = (m_q.size() != 0);
            automatic bit     acc  = in_valid && (!have || out_ready);
            automatic entry_t e;
            e.a   = ref_read(rs1);
            e.b   = use_imm ? imm : ref_read(rs2);
            e.op  = op_in;
            e.ill = !(op_in inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd5});
            if (flush) begin
                m_q.delete();
            end else begin
                if (have && out_ready) void'(m_q.pop_front());
                if (acc) begin
                    m_q.push_back(e);
                    m_last = e;
                end
            end
            if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
        end
    end

    // Monitor: compare the presented entry (or the idle-held fields) mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            automatic entry_t exp = (m_q.size() != 0) ? m_q[0] : m_last;
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, (m_q.size() == 0) || out_ready});
            chk("a", a, exp.a);
            chk("b", b, exp.b);
            chk("opcode", {29'd0, opcode}, {29'd0, exp.op});
            chk("illegal_op", {31'd0, illegal_op}, {31'd0, exp.ill});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [REG_AW-1:0] ad, input logic [XLEN-1:0] d);
        wb_we = 1'b1; wb_addr = ad; wb_data = d;
        cyc();
        wb_we = 1'b0;
    endtask

    task automatic issue(input logic [REG_AW-1:0] r1, input logic [REG_AW-1:0] r2,
                         input logic [XLEN-1:0] im, input logic ui, input logic [2:0] op);
        in_valid = 1'b1; rs1 = r1; rs2 = r2; imm = im; use_imm = ui; op_in = op;
        cyc();
        in_valid = 1'b0;
        cyc();
    endtask

    initial begin
        repeat (2) cyc();
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_a", a, 32'd0);
        reset = 1'b0;
        cyc();
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        issue(5'd5, 5'd0, '0, 1'b0, 3'b010);          // x5 reads zero

        wr(5'd3, 32'h0000_00AA);
        wr(5'd4, 32'h0000_0011);
        wr(5'd0, 32'hFFFF_FFFF);
        issue(5'd3, 5'd4, '0, 1'b0, 3'b000);
        issue(5'd0, 5'd4, '0, 1'b0, 3'b011);
        issue(5'd3, 5'd4, 32'hFFFF_FFF0, 1'b1, 3'b001);
        issue(5'd3, 5'd4, '0, 1'b0, 3'b111);

        // Stall with a pending request, then stream back-to-back.
        out_ready = 1'b0;
        in_valid = 1'b1; rs1 = 5'd4; rs2 = 5'd3; use_imm = 1'b0; op_in = 3'b101;
        repeat (4) cyc();
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rs1 = 5'(i + 1); op_in = 3'(i); cyc();
        end

        // Flush while full with a simultaneous accept: request is dropped.
        rs1 = 5'd3; op_in = 3'b010; flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        cyc();
        issue(5'd3, 5'd4, '0, 1'b0, 3'b010);

        // Write-back coincident with accept of the same register.
        in_valid = 1'b1; rs1 = 5'd3; rs2 = 5'd3; use_imm = 1'b0; op_in = 3'b000;
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_1234;
        cyc();
        in_valid = 1'b0; wb_we = 1'b0;
        #1;
`ifdef OPSTAGE_BYPASS_EN
        chk("bypass_a", a, 32'h0000_1234);
`else
        chk("nobypass_a", a, 32'h0000_00AA);
`endif
        cyc();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rs1       = 5'($urandom);
            rs2       = 5'($urandom);
            imm       = $urandom;
            use_imm   = 1'($urandom);
            op_in     = 3'($urandom);
            wb_we     = 1'($urandom);
            wb_addr   = 5'($urandom);
            wb_data   = $urandom;
            cyc();
        end
        flush = 1'b0; wb_we = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; rs1 = 5'd3;
        cyc();
        in_valid = 1'b0;

        // Asynchronous reset mid-transfer drops the entry at once.
        #1;
        reset = 1'b1;
        #1;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_a", a, 32'd0);
        cyc();
        reset = 1'b0;
        out_ready = 1'b1;
        cyc();
        issue(5'd3, 5'd0, '0, 1'b0, 3'b000);          // x3 cleared by reset
        #1;
        chk("x3_after_reset", a, 32'd0);
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
